// File: rtl/ps2_key_tracker.sv
// ps2_key_tracker
//   Turns the byte stream from the PS/2 receiver (scan code set 2) into
//   per-key held levels and one-cycle press pulses for the game controls.
//   Handles make, break (F0), extended (E0) and Pause (E1) sequences.
//   A partial sequence is dropped after PREFIX_TIMEOUT idle cycles.
//
// Ports
//   clk           system clock (shared with the receiver)
//   rst           synchronous active-high reset
//   keycode       [7:0] newest byte, [15:8] previous byte (not used here)
//   keycode_valid one-cycle strobe, keycode[7:0] is a new byte
//   key_held      per-key level, 1 while down
//                 (0 W, 1 A, 2 S, 3 D, 4 Up, 5 Left, 6 Down, 7 Right, 8 Space, 9 Esc)
//   key_press     one-cycle pulse on a key's 0->1 transition
//   seq_error     one-cycle pulse on an error byte or prefix timeout
module ps2_key_tracker #(
  parameter int unsigned PREFIX_TIMEOUT = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] keycode,
  input  logic        keycode_valid,
  output logic [9:0]  key_held,
  output logic [9:0]  key_press,
  output logic        seq_error
);

  localparam int unsigned TW = $clog2(PREFIX_TIMEOUT + 1);
  localparam logic [TW-1:0] T_LAST = TW'(PREFIX_TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, BRK, EXT, EXT_BRK, SKIP} state_t;

  state_t        state, state_next;
  logic [2:0]    skip_cnt, skip_next;
  logic [TW-1:0] tcnt, tcnt_next;
  logic [9:0]    held_next;
  logic          err_next;
  logic [7:0]    kbyte;
  logic [9:0]    std_mask, ext_mask;
  logic          is_err;
  logic          unused_prev;

  assign kbyte       = keycode[7:0];
  assign unused_prev = ^keycode[15:8];
  assign is_err      = (kbyte == 8'hAA) || (kbyte == 8'hFC) ||
                       (kbyte == 8'h00) || (kbyte == 8'hFF);

  // Keys reached without the E0 prefix.
  function automatic logic [9:0] std_key(input logic [7:0] b);
    logic [9:0] m;
    m = '0;
    case (b)
      8'h1D: m[0] = 1'b1;
      8'h1C: m[1] = 1'b1;
      8'h1B: m[2] = 1'b1;
      8'h23: m[3] = 1'b1;
      8'h29: m[8] = 1'b1;
      8'h76: m[9] = 1'b1;
      // Enter (5A) and P (4D) are recognised but reserved: no output bit yet.
      8'h5A, 8'h4D: m = '0;
      default: m = '0;
    endcase
    return m;
  endfunction

  // Keys reached only with the E0 prefix (arrows).
  function automatic logic [9:0] ext_key(input logic [7:0] b);
    logic [9:0] m;
    m = '0;
    case (b)
      8'h75: m[4] = 1'b1;
      8'h6B: m[5] = 1'b1;
      8'h72: m[6] = 1'b1;
      8'h74: m[7] = 1'b1;
      default: m = '0;
    endcase
    return m;
  endfunction

  assign std_mask = std_key(kbyte);
  assign ext_mask = ext_key(kbyte);

  always_comb begin
    state_next = state;
    skip_next  = skip_cnt;
    tcnt_next  = tcnt;
    held_next  = key_held;
    err_next   = 1'b0;

    if (keycode_valid) begin
      // A byte always beats a timeout expiring in the same cycle.
      tcnt_next = '0;
      if (is_err) begin
        held_next  = '0;
        err_next   = 1'b1;
        state_next = IDLE;
        skip_next  = '0;
      end else begin
        case (state)
          IDLE: begin
            case (kbyte)
              8'hF0: state_next = BRK;
              8'hE0: state_next = EXT;
              8'hE1: begin
                state_next = SKIP;
                skip_next  = 3'd7;
              end
              8'hFA, 8'hEE: state_next = IDLE;
              default: held_next = key_held | std_mask;
            endcase
          end
          BRK: begin
            held_next  = key_held & ~std_mask;
            state_next = IDLE;
          end
          EXT: begin
            if (kbyte == 8'hF0) begin
              state_next = EXT_BRK;
            end else begin
              if (kbyte != 8'h12) held_next = key_held | ext_mask;
              state_next = IDLE;
            end
          end
          EXT_BRK: begin
            held_next  = key_held & ~ext_mask;
            state_next = IDLE;
          end
          SKIP: begin
            skip_next = skip_cnt - 3'd1;
            if (skip_cnt <= 3'd1) begin
              skip_next  = '0;
              state_next = IDLE;
            end
          end
          default: state_next = IDLE;
        endcase
      end
    end else if (state != IDLE) begin
      if (tcnt == T_LAST) begin
        state_next = IDLE;
        err_next   = 1'b1;
        tcnt_next  = '0;
        skip_next  = '0;
      end else begin
        tcnt_next = tcnt + TW'(1);
      end
    end else begin
      tcnt_next = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      skip_cnt  <= '0;
      tcnt      <= '0;
      key_held  <= '0;
      key_press <= '0;
      seq_error <= 1'b0;
    end else begin
      state     <= state_next;
      skip_cnt  <= skip_next;
      tcnt      <= tcnt_next;
      key_held  <= held_next;
      key_press <= held_next & ~key_held;
      seq_error <= err_next;
    end
  end

endmodule
